// File: rtl/craps_pkg.sv
// craps_pkg: shared result codes, FSM states and die helpers for the craps engine
package craps_pkg;
  localparam logic [1:0] RES_WIN   = 2'b00;
  localparam logic [1:0] RES_LOSE  = 2'b01;
  localparam logic [1:0] RES_AGAIN = 2'b10;
  localparam logic [1:0] RES_RESET = 2'b11;
  localparam logic [2:0] DIE_MIN = 3'd1;
  localparam logic [2:0] DIE_MAX = 3'd6;
  typedef enum logic {COME_OUT, POINT} state_t;
  function automatic logic [2:0] die_next(input logic [2:0] d);
    return d == DIE_MAX ? DIE_MIN : d + 3'd1;
  endfunction
endpackage

// File: rtl/roll_debounce.sv
// roll_debounce: synchronizes a bouncy button, accepts a level after a stable run, pulses on rising edge
module roll_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s2, level, level_d;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      level <= 1'b0;
      level_d <= 1'b0;
      cnt <= '0;
      pulse <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      level_d <= level;
      pulse <= level & ~level_d;
      // any cycle matching the accepted level restarts the stability run
      if (s2 == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/craps_roll_ctrl.sv
// craps_roll_ctrl: debounced roll button, free-running dice, craps scoring FSM and point register
module craps_roll_ctrl import craps_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       roll,
  output logic [2:0] x0,
  output logic [2:0] x1,
  output logic [1:0] result,
  output logic [3:0] point,
  output logic       rolled
);
  logic pulse;
  logic [2:0] d0, d1;
  logic [3:0] s;
  state_t state;
  assign s = {1'b0, d0} + {1'b0, d1};
  roll_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk(clk),
    .clr(clr),
    .din(roll),
    .pulse(pulse)
  );
  // d1 steps only when d0 wraps, so the pair walks all 36 combinations
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      d0 <= DIE_MIN;
      d1 <= DIE_MIN;
    end else begin
      d0 <= die_next(d0);
      if (d0 == DIE_MAX) d1 <= die_next(d1);
    end
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      state <= COME_OUT;
      x0 <= 3'd0;
      x1 <= 3'd0;
      result <= RES_RESET;
      point <= 4'd0;
      rolled <= 1'b0;
    end else begin
      rolled <= pulse;
      if (pulse) begin
        x0 <= d0;
        x1 <= d1;
        if (state == COME_OUT) begin
          if (s == 4'd7 || s == 4'd11) begin
            result <= RES_WIN;
            point <= 4'd0;
          end else if (s == 4'd2 || s == 4'd3 || s == 4'd12) begin
            result <= RES_LOSE;
            point <= 4'd0;
          end else begin
            result <= RES_AGAIN;
            point <= s;
            state <= POINT;
          end
        end else if (s == point) begin
          result <= RES_WIN;
          point <= 4'd0;
          state <= COME_OUT;
        end else if (s == 4'd7) begin
          result <= RES_LOSE;
          point <= 4'd0;
          state <= COME_OUT;
        end else result <= RES_AGAIN;
      end
    end
endmodule

// File: tb/tb_craps_roll_ctrl.sv
// tb_craps_roll_ctrl: directed rolls timed against the reset-relative dice sequence
module tb_craps_roll_ctrl;
  localparam int N = 4;
  logic clk = 1'b0, clr = 1'b0, roll = 1'b0;
  logic [2:0] x0, x1;
  logic [1:0] result;
  logic [3:0] point;
  logic rolled;
  int cyc = 0, rcnt = 0, n_chk = 0, n_fail = 0;
  craps_roll_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
    .clk(clk),
    .clr(clr),
    .roll(roll),
    .x0(x0),
    .x1(x1),
    .result(result),
    .point(point),
    .rolled(rolled)
  );
  always #5 clk = ~clk;
  always @(posedge clk or negedge clr)
    if (!clr) cyc <= 0;
    else cyc <= cyc + 1;
  always @(negedge clk) if (rolled) rcnt++;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // dice before edge j are d0=1+(j-1)%6, d1=1+((j-1)/6)%6; capture lands N+4 edges after roll is set
  task automatic roll_at(input int a, input int b, input int er, input int ep);
    int idx, s, j, r0;
    idx = (a - 1) + 6 * (b - 1);
    s = cyc;
    while ((s + N + 3) % 36 != idx) s++;
    while (cyc != s) @(negedge clk);
    r0 = rcnt;
    roll = 1'b1;
    j = s + N + 4;
    while (cyc != j) @(negedge clk);
    chk($sformatf("x0(%0d,%0d)", a, b), x0, a);
    chk($sformatf("x1(%0d,%0d)", a, b), x1, b);
    chk($sformatf("result(%0d,%0d)", a, b), result, er);
    chk($sformatf("point(%0d,%0d)", a, b), point, ep);
    chk($sformatf("rolled(%0d,%0d)", a, b), rolled, 1);
    @(negedge clk);
    chk($sformatf("rolled_low(%0d,%0d)", a, b), rolled, 0);
    roll = 1'b0;
    repeat (N + 8) @(negedge clk);
    chk($sformatf("one_roll(%0d,%0d)", a, b), rcnt - r0, 1);
  endtask
  initial begin
    int r0;
    repeat (3) @(negedge clk);
    chk("rst_x0", x0, 0);
    chk("rst_x1", x1, 0);
    chk("rst_result", result, 3);
    chk("rst_point", point, 0);
    chk("rst_rolled", rolled, 0);
    clr = 1'b1;
    @(negedge clk);
    chk("idle_result", result, 3);
    roll_at(3, 4, 0, 0);
    roll_at(5, 6, 0, 0);
    roll_at(1, 1, 1, 0);
    roll_at(1, 2, 1, 0);
    roll_at(6, 6, 1, 0);
    roll_at(2, 2, 2, 4);
    roll_at(3, 3, 2, 4);
    roll_at(1, 3, 0, 0);
    roll_at(4, 4, 2, 8);
    roll_at(3, 4, 1, 0);
    r0 = rcnt;
    roll = 1'b1;
    repeat (3) @(negedge clk);
    roll = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      roll = 1'b1;
      repeat (2) @(negedge clk);
      roll = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("short_bounce", rcnt - r0, 0);
    chk("hold_result", result, 1);
    chk("hold_x0", x0, 3);
    roll_at(4, 5, 2, 9);
    #2 clr = 1'b0;
    #1;
    chk("async_x0", x0, 0);
    chk("async_x1", x1, 0);
    chk("async_result", result, 3);
    chk("async_point", point, 0);
    chk("async_rolled", rolled, 0);
    @(negedge clk);
    clr = 1'b1;
    roll_at(3, 4, 0, 0);
    r0 = rcnt;
    roll = 1'b1;
    repeat (1000) @(negedge clk);
    chk("long_press", rcnt - r0, 1);
    roll = 1'b0;
    repeat (20) @(negedge clk);
    chk("release", rcnt - r0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
